// File: rtl/lm_display_ctrl.sv
// -----------------------------------------------------------------------------
// lm_display_ctrl
// LED-manager back end. Pops entries (mode + pattern) from the LED-manager FIFO,
// which has a one-cycle registered read latency, and drives the board LEDs as
// steady, blinking, timed flash overlay, or cleared.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-high reset
//   rd_data     FIFO entry: [WIDTH+1:WIDTH] mode, [WIDTH-1:0] pattern
//   fifo_empty  FIFO has no entry
//   rd_en       pop strobe to the FIFO, one cycle per entry
//   leds        registered LED drive
//   busy        high while a flash overlay is running
//
// Modes: 00 steady, 01 blink, 10 timed flash with restore, 11 clear.
//
// Build option: define LM_BLINK_EN to build the blink counter and phase logic.
// Without it, mode 01 behaves exactly like steady mode 00.
// -----------------------------------------------------------------------------
module lm_display_ctrl #(
    parameter int WIDTH       = 8,
    parameter int BLINK_DIV   = 12_000_000,
    parameter int HOLD_CYCLES = 24_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH+1:0] rd_data,
    input  logic             fifo_empty,
    output logic             rd_en,
    output logic [WIDTH-1:0] leds,
    output logic             busy
);

    localparam int CNT_MAX = (BLINK_DIV > HOLD_CYCLES) ? BLINK_DIV : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    localparam logic [1:0] MODE_STEADY = 2'b00;
    localparam logic [1:0] MODE_BLINK  = 2'b01;
    localparam logic [1:0] MODE_FLASH  = 2'b10;
    localparam logic [1:0] MODE_CLEAR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic             rd_en_s;
    logic [1:0]       mode_s;
    logic [WIDTH-1:0] pattern_s;
    logic [WIDTH-1:0] base_r;
    logic [WIDTH-1:0] base_s;
    logic [WIDTH-1:0] leds_r;
    logic [WIDTH-1:0] leds_s;
    logic [WIDTH-1:0] restore_view_s;
    logic [CNT_W-1:0] hold_cnt_r;
    logic             hold_done_s;
    logic             busy_r;

    // Blink view as seen by the shared LED datapath.
    logic             blink_on_s;
    logic             phase_s;
    logic             blink_wrap_s;

    assign mode_s      = rd_data[WIDTH+1:WIDTH];
    assign pattern_s   = rd_data[WIDTH-1:0];
    assign hold_done_s = (state_r == ST_HOLD) && (hold_cnt_r == HOLD_LAST);

`ifdef LM_BLINK_EN
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);

    logic             blink_on_r;
    logic             phase_r;
    logic [CNT_W-1:0] blink_cnt_r;
    logic             blink_run_s;
    logic             fetch_blink_s;
    logic             fetch_stop_s;

    // The blink counter freezes for the whole flash overlay.
    assign blink_run_s   = blink_on_r && (state_r != ST_HOLD);
    assign blink_wrap_s  = blink_run_s && (blink_cnt_r == BLINK_LAST);
    assign fetch_blink_s = (state_r == ST_FETCH) && (mode_s == MODE_BLINK);
    assign fetch_stop_s  = (state_r == ST_FETCH) &&
                           ((mode_s == MODE_STEADY) || (mode_s == MODE_CLEAR));
    assign blink_on_s    = blink_on_r;
    assign phase_s       = phase_r;

    // Blink enable, half-period counter and ON/OFF phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_on_r  <= 1'b0;
            phase_r     <= 1'b1;
            blink_cnt_r <= CNT_ZERO;
        end else if (fetch_blink_s) begin
            // A new blink entry always restarts in the ON phase.
            blink_on_r  <= 1'b1;
            phase_r     <= 1'b1;
            blink_cnt_r <= CNT_ZERO;
        end else if (fetch_stop_s) begin
            blink_on_r  <= 1'b0;
            phase_r     <= 1'b1;
            blink_cnt_r <= CNT_ZERO;
        end else if (blink_wrap_s) begin
            blink_on_r  <= blink_on_r;
            phase_r     <= ~phase_r;
            blink_cnt_r <= CNT_ZERO;
        end else if (blink_run_s) begin
            blink_on_r  <= blink_on_r;
            phase_r     <= phase_r;
            blink_cnt_r <= blink_cnt_r + CNT_ONE;
        end else begin
            blink_on_r  <= blink_on_r;
            phase_r     <= phase_r;
            blink_cnt_r <= blink_cnt_r;
        end
    end
`else
    assign blink_on_s   = 1'b0;
    assign phase_s      = 1'b1;
    assign blink_wrap_s = 1'b0;
`endif

    // Next-state and pop strobe; pops are only issued from IDLE.
    always_comb begin
        state_s = state_r;
        rd_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                rd_en_s = !fifo_empty;
                if (!fifo_empty) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (mode_s == MODE_FLASH) begin
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (hold_done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and the registered busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_HOLD);
        end
    end

    // Overlay duration counter; runs only in HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_r <= CNT_ZERO;
        end else if (state_r != ST_HOLD) begin
            hold_cnt_r <= CNT_ZERO;
        end else if (hold_done_s) begin
            hold_cnt_r <= CNT_ZERO;
        end else begin
            hold_cnt_r <= hold_cnt_r + CNT_ONE;
        end
    end

    // View restored after an overlay: the base, or the blink phase in effect.
    assign restore_view_s = (blink_on_s && !phase_s) ? {WIDTH{1'b0}} : base_r;

    // Base pattern and LED next values: entry decode wins over blink toggling.
    always_comb begin
        base_s = base_r;
        leds_s = leds_r;
        if (state_r == ST_FETCH) begin
            case (mode_s)
                MODE_STEADY, MODE_BLINK: begin
                    base_s = pattern_s;
                    leds_s = pattern_s;
                end
                MODE_FLASH: begin
                    leds_s = pattern_s;
                end
                MODE_CLEAR: begin
                    base_s = {WIDTH{1'b0}};
                    leds_s = {WIDTH{1'b0}};
                end
                default: begin
                    base_s = base_r;
                    leds_s = leds_r;
                end
            endcase
        end else if (hold_done_s) begin
            leds_s = restore_view_s;
        end else if (blink_wrap_s) begin
            // Phase is about to toggle, so show the view of the new phase.
            leds_s = phase_s ? {WIDTH{1'b0}} : base_r;
        end else begin
            leds_s = leds_r;
        end
    end

    // Base and LED registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_r <= {WIDTH{1'b0}};
            leds_r <= {WIDTH{1'b0}};
        end else begin
            base_r <= base_s;
            leds_r <= leds_s;
        end
    end

    // The pop strobe is suppressed while reset is asserted.
    assign rd_en = rd_en_s && !rst;
    assign leds  = leds_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_lm_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lm_display_ctrl
// Directed bench for lm_display_ctrl with WIDTH=8, BLINK_DIV=4, HOLD_CYCLES=6.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 time
// unit after that. Blink expectations follow whether LM_BLINK_EN is defined.
// -----------------------------------------------------------------------------
module tb_lm_display_ctrl;

`ifdef LM_BLINK_EN
    localparam bit BLINK_BUILT = 1'b1;
`else
    localparam bit BLINK_BUILT = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [9:0] rd_data;
    logic       fifo_empty;
    logic       rd_en;
    logic [7:0] leds;
    logic       busy;

    int n_checks;
    int n_fail;

    lm_display_ctrl #(
        .WIDTH      (8),
        .BLINK_DIV  (4),
        .HOLD_CYCLES(6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_data   (rd_data),
        .fifo_empty(fifo_empty),
        .rd_en     (rd_en),
        .leds      (leds),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one entry, check the pop strobe, then let the FIFO go empty.
    // Returns in the FETCH cycle; leds update on the following edge.
    task automatic pop_one(input logic [9:0] entry, input string tag);
        rd_data    = entry;
        fifo_empty = 1'b0;
        #1;
        check_val({tag, "_rd_en"}, 32'(rd_en), 32'd1);
        tick();
        fifo_empty = 1'b1;
        #1;
        check_val({tag, "_fetch_no_pop"}, 32'(rd_en), 32'd0);
    endtask

    logic [7:0] exp_leds;

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        fifo_empty = 1'b1;
        rd_data    = 10'h000;
        #2;
        check_val("reset_leds", 32'(leds), 32'h0);
        check_val("reset_rd_en", 32'(rd_en), 32'd0);
        check_val("reset_busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_val("idle_empty_no_pop", 32'(rd_en), 32'd0);
        check_val("idle_leds", 32'(leds), 32'h0);

        // Steady A5: leds change two edges after the pop.
        tick();
        pop_one({2'b00, 8'hA5}, "steady");
        check_val("steady_not_yet", 32'(leds), 32'h0);
        tick();
        #1;
        check_val("steady_leds", 32'(leds), 32'hA5);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("steady_hold", 32'(leds), 32'hA5);
            check_val("steady_no_pop", 32'(rd_en), 32'd0);
        end

        // Blink 0F: each value held 4 cycles, starting ON.
        tick();
        pop_one({2'b01, 8'h0F}, "blink");
        tick();
        for (int i = 0; i < 12; i++) begin
            if (BLINK_BUILT && (((i / 4) % 2) == 1)) begin
                exp_leds = 8'h00;
            end else begin
                exp_leds = 8'h0F;
            end
            check_val("blink_seq", 32'(leds), 32'(exp_leds));
            tick();
        end

        // Blink has just wrapped into OFF; flash FF over it.
        exp_leds = BLINK_BUILT ? 8'h00 : 8'h0F;
        check_val("pre_flash_phase", 32'(leds), 32'(exp_leds));
        rd_data    = {2'b10, 8'hFF};
        fifo_empty = 1'b0;
        #1;
        check_val("flash_rd_en", 32'(rd_en), 32'd1);
        tick();
        check_val("flash_fetch_no_pop", 32'(rd_en), 32'd0);
        check_val("flash_fetch_leds", 32'(leds), 32'(exp_leds));
        tick();
        for (int j = 0; j < 6; j++) begin
            check_val("flash_leds", 32'(leds), 32'hFF);
            check_val("flash_busy", 32'(busy), 32'd1);
            check_val("flash_no_pop", 32'(rd_en), 32'd0);
            if (j == 5) begin
                fifo_empty = 1'b1;
            end
            tick();
        end
        check_val("flash_exit_busy", 32'(busy), 32'd0);
        check_val("flash_restore0", 32'(leds), 32'(exp_leds));
        tick();
        check_val("flash_restore1", 32'(leds), 32'(exp_leds));
        tick();
        check_val("blink_resume_on", 32'(leds), 32'h0F);

        // Back-to-back: {00,01}, {00,02}, {11,AB}.
        tick();
        rd_data    = {2'b00, 8'h01};
        fifo_empty = 1'b0;
        #1;
        check_val("b2b_pop0", 32'(rd_en), 32'd1);
        tick();
        check_val("b2b_fetch0", 32'(rd_en), 32'd0);
        tick();
        check_val("b2b_leds0", 32'(leds), 32'h01);
        check_val("b2b_pop1", 32'(rd_en), 32'd1);
        tick();
        rd_data = {2'b00, 8'h02};
        check_val("b2b_fetch1", 32'(rd_en), 32'd0);
        tick();
        check_val("b2b_leds1", 32'(leds), 32'h02);
        check_val("b2b_pop2", 32'(rd_en), 32'd1);
        tick();
        rd_data    = {2'b11, 8'hAB};
        fifo_empty = 1'b1;
        tick();
        check_val("b2b_clear", 32'(leds), 32'h00);
        check_val("b2b_no_pop", 32'(rd_en), 32'd0);
        tick();
        tick();
        check_val("clear_hold", 32'(leds), 32'h00);

        // Async reset in the middle of a flash overlay.
        rd_data    = {2'b10, 8'h5A};
        fifo_empty = 1'b0;
        tick();
        tick();
        check_val("rst_pre_flash", 32'(leds), 32'h5A);
        check_val("rst_pre_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("rst_async_leds", 32'(leds), 32'h0);
        check_val("rst_async_busy", 32'(busy), 32'd0);
        check_val("rst_async_rd_en", 32'(rd_en), 32'd0);
        tick();
        fifo_empty = 1'b1;
        rst        = 1'b0;
        tick();
        check_val("post_rst_no_pop", 32'(rd_en), 32'd0);
        check_val("post_rst_leds", 32'(leds), 32'h0);
        check_val("post_rst_busy", 32'(busy), 32'd0);

        // Recovery: a fresh entry after reset shows up on schedule.
        pop_one({2'b01, 8'h3C}, "recover");
        tick();
        check_val("recover_leds", 32'(leds), 32'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
